// File: rtl/vga_plotter.sv
// Pixel-write sequencer: queues plot requests in a small FIFO and drives the VGA adapter
// write port one pixel per cycle, with an order-preserving full-screen clear sweep.
module vga_plotter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot_valid,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [14:0] plot_color,
  output logic        plot_ready,
  input  logic        clear_start,
  input  logic [14:0] clear_color,
  output logic        busy,
  output logic [7:0]  adapter_x,
  output logic [6:0]  adapter_y,
  output logic [14:0] adapter_color,
  output logic        adapter_plot,
  output logic [7:0]  drop_count
);

  // state | meaning
  // IDLE  | draining the FIFO, one pop per cycle
  // PEND  | clear requested, intake closed until the FIFO drains
  // CLEAR | sweeping the screen with the latched colour
  typedef enum logic [1:0] {IDLE, PEND, CLEAR} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [7:0]  X_END    = 8'(WIDTH);
  localparam logic [6:0]  Y_END    = 7'(HEIGHT);
  localparam logic [7:0]  X_LAST   = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_LAST   = 7'(HEIGHT - 1);

  state_t      state;
  logic [29:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        fifo_empty, fifo_full;
  logic        accept, in_range, push, pop;
  logic [7:0]  clr_x;
  logic [6:0]  clr_y;
  logic        clr_done;
  logic [14:0] clr_color;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign plot_ready = !reset && !fifo_full && (state != PEND);
  assign accept     = plot_valid && plot_ready;
  assign in_range   = (plot_x < X_END) && (plot_y < Y_END);
  assign push       = accept && in_range;
  assign pop        = (state != CLEAR) && !fifo_empty;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {plot_color, plot_y, plot_x};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      adapter_x     <= '0;
      adapter_y     <= '0;
      adapter_color <= '0;
      adapter_plot  <= 1'b0;
      drop_count    <= '0;
      clr_x         <= '0;
      clr_y         <= '0;
      clr_done      <= 1'b0;
      clr_color     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (accept && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;

      adapter_plot <= 1'b0;
      if (pop) begin
        {adapter_color, adapter_y, adapter_x} <= fifo_mem[rd_ptr];
        adapter_plot <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (clear_start) begin
            clr_color <= clear_color;
            state     <= fifo_empty ? CLEAR : PEND;
          end
        end
        PEND: begin
          // Intake is closed here, so a count of one means this edge pops the last entry.
          if (fifo_empty || count == ONE_CNT) state <= CLEAR;
        end
        CLEAR: begin
          if (clr_done) begin
            clr_done <= 1'b0;
            state    <= IDLE;
          end else begin
            adapter_x     <= clr_x;
            adapter_y     <= clr_y;
            adapter_color <= clr_color;
            adapter_plot  <= 1'b1;
            if (clr_x == X_LAST) begin
              clr_x <= '0;
              if (clr_y == Y_LAST) begin
                clr_y    <= '0;
                clr_done <= 1'b1;
              end else begin
                clr_y <= clr_y + 1'b1;
              end
            end else begin
              clr_x <= clr_x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plotter.sv
// Directed self-checking bench for vga_plotter: single plot, clear sweep, backpressure,
// pending clear with reset abort, and out-of-range drop saturation.
module tb_vga_plotter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        plot_valid = 1'b0;
  logic [7:0]  plot_x = '0;
  logic [6:0]  plot_y = '0;
  logic [14:0] plot_color = '0;
  logic        clear_start = 1'b0;
  logic [14:0] clear_color = '0;
  logic        plot_ready, busy, adapter_plot;
  logic [7:0]  adapter_x, drop_count;
  logic [6:0]  adapter_y;
  logic [14:0] adapter_color;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bx [6];
  logic [6:0]  by [6];
  logic [14:0] bc [6];
  int acc, drawn;

  always #5 clock = ~clock;

  vga_plotter dut (
    .clock(clock), .reset(reset),
    .plot_valid(plot_valid), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
    .plot_ready(plot_ready), .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .adapter_x(adapter_x), .adapter_y(adapter_y),
    .adapter_color(adapter_color), .adapter_plot(adapter_plot), .drop_count(drop_count)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic single_plot(input string tag);
    plot_valid = 1'b1; plot_x = 8'd12; plot_y = 7'd34; plot_color = 15'h7C00;
    #1;
    check({tag, "_ready"}, plot_ready, 1);
    tick;
    plot_valid = 1'b0;
    check({tag, "_lat1"}, adapter_plot, 0);
    tick;
    check({tag, "_strobe"}, adapter_plot, 1);
    check({tag, "_pix"}, {adapter_x, adapter_y, adapter_color}, {8'd12, 7'd34, 15'h7C00});
    tick;
    check({tag, "_once"}, adapter_plot, 0);
    check({tag, "_hold"}, {adapter_x, adapter_y, adapter_color}, {8'd12, 7'd34, 15'h7C00});
    check({tag, "_drop"}, drop_count, 0);
  endtask

  task automatic bp_load(input int k);
    plot_x = bx[k]; plot_y = by[k]; plot_color = bc[k];
  endtask

  task automatic bp_step;
    logic fire;
    fire = plot_valid && plot_ready;
    tick;
    if (fire) begin
      acc++;
      if (acc < 6) bp_load(acc);
      else plot_valid = 1'b0;
    end
    if (adapter_plot && !busy) begin
      if (drawn < 6)
        check($sformatf("bp_order%0d", drawn), {adapter_x, adapter_y, adapter_color},
              {bx[drawn], by[drawn], bc[drawn]});
      drawn++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, cyc, strobes;

    // reset state
    tick; tick;
    check("rst_plot", adapter_plot, 0);
    check("rst_pix", {adapter_x, adapter_y, adapter_color}, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", plot_ready, 0);
    reset = 1'b0;

    single_plot("single");

    // full clear sweep
    clear_color = 15'h001F; clear_start = 1'b1;
    tick;
    clear_start = 1'b0; clear_color = 15'h1234;
    check("clr_busy", busy, 1);
    check("clr_first_gap", adapter_plot, 0);
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      tick;
      if (!adapter_plot || adapter_x != 8'(i % 160) || adapter_y != 7'(i / 160) ||
          adapter_color != 15'h001F) bad++;
      if (i == 0)     check("clr_pix0", {adapter_x, adapter_y}, {8'd0, 7'd0});
      if (i == 160)   check("clr_pix160", {adapter_x, adapter_y}, {8'd0, 7'd1});
      if (i == 19199) begin
        check("clr_pixlast", {adapter_x, adapter_y}, {8'd159, 7'd119});
        check("clr_busy_last", busy, 1);
      end
    end
    check("clr_sweep_errs", bad, 0);
    tick;
    check("clr_busy_drop", busy, 0);
    check("clr_end_plot", adapter_plot, 0);

    // backpressure during a clear; req0 arrives together with clear_start on an empty FIFO
    for (int k = 0; k < 6; k++) begin
      bx[k] = 8'(10 + k); by[k] = 7'(20 + k); bc[k] = 15'(16'h0100 + k);
    end
    acc = 0; drawn = 0;
    clear_color = 15'h0C0C; clear_start = 1'b1;
    plot_valid = 1'b1; bp_load(0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("bp_ready%0d", c), plot_ready, (c < 4) ? 1 : 0);
      bp_step;
      clear_start = 1'b0;
      if (c == 0) check("bp_busy", busy, 1);
    end
    check("bp_accepted4", acc, 4);
    cyc = 0;
    while (busy && cyc < 25000) begin
      bp_step;
      cyc++;
    end
    check("bp_clear_done", busy, 0);
    for (int c = 0; c < 12; c++) bp_step;
    check("bp_accepted6", acc, 6);
    check("bp_drawn", drawn, 6);

    // pending clear behind three queued plots, then reset mid-clear
    clear_color = 15'h7FFF;
    plot_valid = 1'b1; plot_x = 8'd1; plot_y = 7'd2; plot_color = 15'h0111;
    tick;
    check("pend_lat", adapter_plot, 0);
    plot_x = 8'd3; plot_y = 7'd4; plot_color = 15'h0222;
    tick;
    check("pend_p0", {adapter_plot, adapter_x, adapter_y, adapter_color}, {1'b1, 8'd1, 7'd2, 15'h0111});
    plot_x = 8'd5; plot_y = 7'd6; plot_color = 15'h0333; clear_start = 1'b1;
    tick;
    plot_valid = 1'b0; clear_start = 1'b0; clear_color = 15'h0000;
    check("pend_p1", {adapter_plot, adapter_x, adapter_y, adapter_color}, {1'b1, 8'd3, 7'd4, 15'h0222});
    check("pend_busy", busy, 1);
    check("pend_ready", plot_ready, 0);
    tick;
    check("pend_p2", {adapter_plot, adapter_x, adapter_y, adapter_color}, {1'b1, 8'd5, 7'd6, 15'h0333});
    tick;
    check("pend_clr0", {adapter_plot, adapter_x, adapter_y, adapter_color}, {1'b1, 8'd0, 7'd0, 15'h7FFF});
    bad = 0;
    for (int i = 1; i < 5000; i++) begin
      if (i == 100) clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      if (!adapter_plot || adapter_x != 8'(i % 160) || adapter_y != 7'(i / 160) ||
          adapter_color != 15'h7FFF) bad++;
    end
    check("pend_sweep_errs", bad, 0);
    reset = 1'b1;
    tick;
    check("midrst_plot", adapter_plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", plot_ready, 0);
    check("midrst_pix", {adapter_x, adapter_y, adapter_color}, 0);
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (adapter_plot) strobes++;
    end
    check("midrst_quiet", strobes, 0);
    single_plot("after_rst");

    // range drops and saturation
    plot_valid = 1'b1; plot_x = 8'd0; plot_y = 7'd120; plot_color = 15'h0001;
    tick;
    plot_valid = 1'b0;
    tick;
    check("range_y_plot", adapter_plot, 0);
    check("range_y_drop", drop_count, 1);
    strobes = 0;
    plot_valid = 1'b1; plot_x = 8'd160; plot_y = 7'd0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (adapter_plot) strobes++;
    end
    plot_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (adapter_plot) strobes++;
    end
    check("range_x_strobes", strobes, 0);
    check("range_sat", drop_count, 255);
    plot_valid = 1'b1; plot_x = 8'd159; plot_y = 7'd119; plot_color = 15'h2AAA;
    tick;
    plot_valid = 1'b0;
    tick;
    check("range_corner", {adapter_plot, adapter_x, adapter_y, adapter_color}, {1'b1, 8'd159, 7'd119, 15'h2AAA});
    check("range_sat_hold", drop_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
